// File: rtl/bcd_display_scan_pkg.sv
// Shared glyph constants, scan-state encoding and the BCD digit lookup
// used by the multiplexed 7-segment scanner.
package bcd_display_scan_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    GAP   = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  function automatic logic [6:0] digit_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd_display_scan_seg7_decode.sv
// Combinational glyph selector: error beats minus beats blank beats the
// decimal digit; a non-decimal nibble falls through to 'E'.
module seg7_decode
  import bcd_display_scan_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       minus,
  input  logic       error,
  output logic [6:0] seg
);

  always_comb begin
    if (error) begin
      seg = SEG_E;
    end else if (minus) begin
      seg = SEG_MINUS;
    end else if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = digit_glyph(nibble);
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed common-anode display scanner: double-buffered BCD value that
// commits only at the frame wrap, one blank gap cycle between digit slots.
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int CLK_DIV  = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DWIDTH-1:0]     bcd_in,
  input  logic                  load,
  input  logic                  neg_in,
  input  logic                  err_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DWIDTH/4-1:0]   an,
  output logic                  frame
);

  localparam int NDIG = DWIDTH / 4;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int SW   = $clog2(NDIG + 1);
  localparam int CW   = $clog2(CLK_DIV);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NDIG - 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(CLK_DIV - 1);

  scan_state_e         state_reg, state_next;
  logic [CW-1:0]       slot_cnt_reg, slot_cnt_next;
  logic [IW-1:0]       idx_reg, idx_next;

  logic [DWIDTH-1:0]   pend_bcd_reg, cur_bcd_reg;
  logic                pend_neg_reg, pend_err_reg, pend_valid_reg;
  logic                cur_neg_reg, cur_err_reg;

  logic [6:0]          seg_reg, seg_next;
  logic [NDIG-1:0]     an_reg, an_next;
  logic                frame_reg, dp_reg;

  logic                wrap, commit;
  logic [NDIG-1:0]     nz;
  logic [SW-1:0]       sig_cnt;
  logic [SW-1:0]       idx_ext;
  logic [3:0]          cur_nib;
  logic                dec_blank, dec_minus, dec_error;
  logic [6:0]          glyph;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= GAP;
      slot_cnt_reg <= '0;
      idx_reg      <= '0;
      seg_reg      <= SEG_BLANK;
      an_reg       <= '1;
      frame_reg    <= 1'b0;
      dp_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      slot_cnt_reg <= slot_cnt_next;
      idx_reg      <= idx_next;
      seg_reg      <= seg_next;
      an_reg       <= an_next;
      frame_reg    <= commit;
      dp_reg       <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    slot_cnt_next = slot_cnt_reg;
    idx_next      = idx_reg;
    case (state_reg)
      GAP: begin
        state_next    = DRIVE;
        slot_cnt_next = slot_cnt_reg + 1'b1;
      end
      DRIVE: begin
        if (slot_cnt_reg == LAST_SLOT) begin
          state_next    = GAP;
          slot_cnt_next = '0;
          idx_next      = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end else begin
          slot_cnt_next = slot_cnt_reg + 1'b1;
        end
      end
      default: state_next = GAP;
    endcase
  end

  // Outputs follow the next state so the glyph lands on the first DRIVE cycle
  always_comb begin
    an_next  = '1;
    seg_next = SEG_BLANK;
    if (state_next == DRIVE) begin
      an_next[idx_next] = 1'b0;
      seg_next          = glyph;
    end
  end

  assign wrap   = (state_reg == DRIVE) && (state_next == GAP) && (idx_reg == LAST_IDX);
  assign commit = wrap && (pend_valid_reg || load);

  // Double buffer: a load coinciding with the wrap bypasses the pending stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_bcd_reg   <= '0;
      pend_neg_reg   <= 1'b0;
      pend_err_reg   <= 1'b0;
      pend_valid_reg <= 1'b0;
      cur_bcd_reg    <= '0;
      cur_neg_reg    <= 1'b0;
      cur_err_reg    <= 1'b0;
    end else if (commit) begin
      pend_valid_reg <= 1'b0;
      if (load) begin
        cur_bcd_reg <= bcd_in;
        cur_neg_reg <= neg_in;
        cur_err_reg <= err_in;
      end else begin
        cur_bcd_reg <= pend_bcd_reg;
        cur_neg_reg <= pend_neg_reg;
        cur_err_reg <= pend_err_reg;
      end
    end else if (load) begin
      pend_bcd_reg   <= bcd_in;
      pend_neg_reg   <= neg_in;
      pend_err_reg   <= err_in;
      pend_valid_reg <= 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_nz
      assign nz[gi] = |cur_bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Number of significant digits; a zero value still counts one digit
  always_comb begin
    sig_cnt = SW'(1);
    for (int k = 0; k < NDIG; k++) begin
      if (nz[k]) sig_cnt = SW'(k + 1);
    end
  end

  assign idx_ext = SW'(idx_reg);
  assign cur_nib = cur_bcd_reg[idx_reg*4 +: 4];

  always_comb begin
    dec_blank = 1'b0;
    dec_minus = 1'b0;
    dec_error = 1'b0;
    if (cur_err_reg || (cur_neg_reg && (sig_cnt == SW'(NDIG)))) begin
      dec_error = (idx_reg == '0);
      dec_blank = (idx_reg != '0);
    end else if (cur_nib > 4'd9) begin
      dec_error = 1'b1;
    end else if (BLANK_LZ && (idx_ext >= sig_cnt)) begin
      dec_minus = cur_neg_reg && (idx_ext == sig_cnt);
      dec_blank = !(cur_neg_reg && (idx_ext == sig_cnt));
    end
  end

  seg7_decode u_decode (
    .nibble (cur_nib),
    .blank  (dec_blank),
    .minus  (dec_minus),
    .error  (dec_error),
    .seg    (glyph)
  );

  assign seg   = seg_reg;
  assign an    = an_reg;
  assign frame = frame_reg;
  assign dp    = dp_reg;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench: stimulus queues the expected {an,seg} per digit slot,
// a negedge monitor pops one entry at the start of every DRIVE slot.
module tb_bcd_display_scan;

  localparam int DWIDTH  = 32;
  localparam int CLK_DIV = 4;
  localparam logic [6:0] B = 7'h7F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        neg_in = 1'b0;
  logic        err_in = 1'b0;
  logic [31:0] bcd_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame;

  int n_checks = 0;
  int n_pass = 0;
  int frame_cnt = 0;
  logic [14:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_display_scan #(
    .DWIDTH   (DWIDTH),
    .CLK_DIV  (CLK_DIV),
    .BLANK_LZ (1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bcd_in (bcd_in),
    .load   (load),
    .neg_in (neg_in),
    .err_in (err_in),
    .seg    (seg),
    .dp     (dp),
    .an     (an),
    .frame  (frame)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_digit(input int k, input logic [6:0] g);
    logic [7:0] a;
    a = 8'hFF;
    a[k] = 1'b0;
    exp_q.push_back({a, g});
  endtask

  task automatic push_frame(input logic [6:0] g0, g1, g2, g3, g4, g5, g6, g7);
    push_digit(0, g0); push_digit(1, g1); push_digit(2, g2); push_digit(3, g3);
    push_digit(4, g4); push_digit(5, g5); push_digit(6, g6); push_digit(7, g7);
  endtask

  task automatic do_load(input logic [31:0] v, input logic n, input logic e);
    @(negedge clk);
    bcd_in = v; neg_in = n; err_in = e; load = 1'b1;
    $display("load bcd=%h neg=%b err=%b", v, n, e);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    while (!frame && n < 300) begin @(negedge clk); n++; end
    check("frame_seen", 32'(frame), 32'd1);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_an(input logic [7:0] v);
    int n = 0;
    while (an != v && n < 100) begin @(negedge clk); n++; end
    check("wait_an", 32'(an), 32'(v));
  endtask

  // Monitor: slot contents, drive length and single-cycle gaps
  logic [7:0]  prev_an = 8'hFF;
  logic [14:0] e_ent;
  int          run_len = 0;
  int          gap_len = 0;
  bit          seen_drive = 1'b0;

  always @(negedge clk) begin
    if (frame) frame_cnt++;
    if (!rst_n) begin
      run_len = 0; gap_len = 0; seen_drive = 1'b0; prev_an = 8'hFF;
    end else begin
      if (an == 8'hFF) begin
        check("gap_seg", 32'(seg), 32'(B));
        if (run_len > 0) begin
          check("drive_len", 32'(run_len), 32'(CLK_DIV - 1));
          run_len = 0;
        end
        gap_len++;
      end else begin
        if (prev_an == 8'hFF) begin
          if (seen_drive) check("gap_len", 32'(gap_len), 32'd1);
          seen_drive = 1'b1;
          gap_len = 0;
          check("dp_off", 32'(dp), 32'd1);
          if (exp_q.size() > 0) begin
            e_ent = exp_q.pop_front();
            $display("slot an=%h seg=%h exp_an=%h exp_seg=%h", an, seg, e_ent[14:7], e_ent[6:0]);
            check("slot_an", 32'(an), 32'(e_ent[14:7]));
            check("slot_seg", 32'(seg), 32'(e_ent[6:0]));
          end
        end
        run_len++;
      end
      prev_an = an;
    end
  end

  initial begin
    int fc0;
    // Reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_an", 32'(an), 32'hFF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_frame", 32'(frame), 32'd0);
      check("rst_dp", 32'(dp), 32'd1);
    end
    push_frame(7'h40, B, B, B, B, B, B, B);
    rst_n = 1'b1;
    // One GAP cycle after reset, then digit 0 drives
    @(negedge clk);
    check("first_drive_an", 32'(an), 32'hFE);
    check("first_drive_seg", 32'(seg), 32'h40);
    wait_empty();

    do_load(32'h0000_1234, 1'b0, 1'b0);
    wait_frame();
    push_frame(7'h19, 7'h30, 7'h24, 7'h79, B, B, B, B);
    wait_empty();

    do_load(32'h0000_0045, 1'b1, 1'b0);
    wait_frame();
    push_frame(7'h12, 7'h19, 7'h3F, B, B, B, B, B);
    wait_empty();

    // Two loads inside one frame: old value holds until the wrap, last load wins
    wait_an(8'hFE);
    @(negedge clk);
    push_digit(1, 7'h19); push_digit(2, 7'h3F); push_digit(3, B); push_digit(4, B);
    push_digit(5, B); push_digit(6, B); push_digit(7, B);
    fc0 = frame_cnt;
    bcd_in = 32'h0000_0011; neg_in = 1'b0; err_in = 1'b0; load = 1'b1;
    $display("load bcd=%h neg=0 err=0", bcd_in);
    @(negedge clk);
    bcd_in = 32'h0000_0099;
    $display("load bcd=%h neg=0 err=0", bcd_in);
    @(negedge clk);
    load = 1'b0;
    wait_frame();
    push_frame(7'h10, 7'h10, B, B, B, B, B, B);
    wait_empty();
    check("frame_pulses", 32'(frame_cnt - fc0), 32'd1);

    do_load(32'h1234_5678, 1'b1, 1'b0);
    wait_frame();
    push_frame(7'h06, B, B, B, B, B, B, B);
    wait_empty();

    do_load(32'h0000_0003, 1'b0, 1'b1);
    wait_frame();
    push_frame(7'h06, B, B, B, B, B, B, B);
    wait_empty();

    do_load(32'h0000_000A, 1'b0, 1'b0);
    wait_frame();
    push_frame(7'h06, B, B, B, B, B, B, B);
    wait_empty();

    // Load mid-frame, then reset the next cycle: pending value must vanish
    wait_an(8'hFE);
    @(negedge clk);
    bcd_in = 32'h0000_0777; neg_in = 1'b0; err_in = 1'b0; load = 1'b1;
    $display("load bcd=%h neg=0 err=0", bcd_in);
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_an", 32'(an), 32'hFF);
    push_frame(7'h40, B, B, B, B, B, B, B);
    push_frame(7'h40, B, B, B, B, B, B, B);
    fc0 = frame_cnt;
    rst_n = 1'b1;
    wait_empty();
    check("no_commit_after_reset", 32'(frame_cnt - fc0), 32'd0);

    check("queue_left", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
Consumes packed BCD words from the binary-to-BCD converter and drives a multiplexed common-anode 7-segment display.
- Double-buffers the value so a new word commits only at a frame boundary; the display never tears mid-frame.
- Scans digits with a programmable slot time and inserts an anti-ghosting blank cycle between digits.
- Applies leading-zero blanking, a minus sign and an error glyph.

Parameters:
DWIDTH, 32, BCD input width; multiple of 4; NDIG = DWIDTH/4 digits (default 8)
CLK_DIV, 50000, clk cycles per digit slot; minimum 2
BLANK_LZ, 1, 1 = blank leading zeros (digit 0 always shown); 0 = show all digits

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
bcd_in  in  DWIDTH  packed BCD, digit k = bcd_in[4k+3:4k], digit 0 = ones
load  in  1  capture strobe for bcd_in/neg_in/err_in; driven by converter done
neg_in  in  1  value is negative
err_in  in  1  force error display
seg  out  7  segments {g,f,e,d,c,b,a}, active low
dp  out  1  decimal point, active low; always 1 (off) in this revision
an  out  NDIG  digit anodes, active low, one-hot-low while driving
frame  out  1  one-cycle pulse when digit index wraps to 0 (commit point)

Behaviour:
- Interface: one clock; reset is synchronous and active-low; ports are clk and rst_n.
- Reset (rst_n=0 at posedge):
  - Outputs: seg=7'h7F, dp=1, an=all 1, frame=0.
  - State: slot counter=0, digit index=0, state=GAP.
  - Registers: committed value=0, neg=0, err=0, pending_valid=0.
- Reset mid-frame or mid-load discards pending data; no partial commit.
- All outputs are registered.
- Capture: on load=1 the triple {bcd_in, neg_in, err_in} goes to the pending register and pending_valid is set. Multiple loads in one frame: last wins.
- FSM, two states:
  - GAP: lasts 1 cycle; an=all 1; seg=7'h7F; then goes to DRIVE.
  - DRIVE: lasts CLK_DIV-1 cycles; an[idx]=0, others 1; seg=glyph(idx). Then goes to GAP with idx=idx+1, wrapping NDIG-1 -> 0.
  - Slot period = CLK_DIV cycles exactly.
- Commit: occurs on the GAP cycle whose idx becomes 0.
  - If pending_valid, the committed registers take the pending value, pending_valid clears and frame=1 that cycle.
  - A load in that same cycle commits bcd_in directly and leaves pending_valid=0.
- Significant digits: S = index of the highest nonzero digit + 1, with S=1 for value 0.
- Glyph for digit k, in priority order:
  - err: k=0 shows 'E', others blank.
  - neg && S==NDIG (no room for sign): same as err.
  - Nibble > 9: 'E' at that digit.
  - BLANK_LZ && k >= S: blank, except neg && k==S shows '-'.
  - Otherwise: decimal glyph.
- Encodings (active low):
  - Digits: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10.
  - Symbols: '-'=3F, E=06, blank=7F.
- Glyph output is registered: the decode for idx is prepared on the GAP cycle and is valid on the first DRIVE cycle.

Decomposition:
- Shared include file holds:
  - The glyph constants SEG_0..SEG_9, SEG_MINUS, SEG_E, SEG_BLANK.
  - The state encodings GAP/DRIVE.
- One combinational sub-module, seg7_decode: {nibble, blank, minus, error} -> seg[6:0].
- Leading-digit detection and the FSM stay in bcd_display_scan.

Test Plan:
Benches use CLK_DIV=4 and DWIDTH=32.
1. Reset: hold rst_n=0 for 3 cycles, then release -> an=FF, seg=7F during reset. First DRIVE cycle, 2 cycles after release: an=FE, seg=40 ("0"). Digits 1-7 blank (7F) on their slots.
2. Load 32'h00001234, neg=0 -> after next frame pulse, digits 0..3 show 19,30,24,79 and digits 4..7 show 7F. Every GAP cycle shows an=FF.
3. Load 32'h00000045, neg=1 -> digit0=12, digit1=19, digit2=3F ('-'), digits 3..7 blank.
4. Load 32'h12345678, neg=1 -> digit0=06 ('E'), all others 7F. Also: err_in=1 with any value gives the same result.
5. Mid-frame torn-load check:
   - Load 32'h00000011, then 32'h00000099 within the same frame, and sample digit 1 of the current frame before the wrap.
   - Until the wrap, digit 1 shows the old committed value.
   - After the wrap, digits 0 and 1 both show 10 ("9").
   - frame pulses exactly once.
6. Load 32'h0000000A -> digit0=06. Then assert rst_n=0 in the cycle after a load -> pending is discarded and the display returns to "0".
